// File: rtl/alu_issue_arbiter.sv
// Shares one external registered ALU between two requesters. Each operation walks
// IDLE -> EXEC -> LATCH -> RESP and its result goes back to the requester that issued it.
module alu_issue_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_funct3,
  input  logic [XLEN-1:0] req0_op_a,
  input  logic [XLEN-1:0] req0_op_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_funct3,
  input  logic [XLEN-1:0] req1_op_a,
  input  logic [XLEN-1:0] req1_op_b,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            alu_enable,
  output logic [2:0]      alu_funct3,
  output logic [XLEN-1:0] alu_data_1,
  output logic [XLEN-1:0] alu_data_2,
  input  logic [XLEN-1:0] alu_data_out
);

  typedef enum logic [1:0] {StIdle, StExec, StLatch, StResp} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [XLEN-1:0] result_q, result_d;

  logic grant_sel;  // 0 = requester 0, 1 = requester 1
  logic resp_hs;

  // Pick the winner among valid requesters; ties go by mode.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = (FIXED_PRIORITY != 0) ? 1'b0 : ptr_q;
    end else begin
      grant_sel = req1_valid;
    end
  end

  // Next-state logic and all outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    funct3_d   = funct3_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp_data  = '0;
    busy       = (state_q != StIdle);
    alu_enable = 1'b0;
    alu_funct3 = '0;
    alu_data_1 = '0;
    alu_data_2 = '0;
    resp_hs    = owner_q ? resp1_ready : resp0_ready;

    unique case (state_q)
      StIdle: begin
        req0_ready = req0_valid && !grant_sel;
        req1_ready = req1_valid && grant_sel;
        if (req0_valid || req1_valid) begin
          owner_d  = grant_sel;
          funct3_d = grant_sel ? req1_funct3 : req0_funct3;
          op_a_d   = grant_sel ? req1_op_a : req0_op_a;
          op_b_d   = grant_sel ? req1_op_b : req0_op_b;
          state_d  = StExec;
        end
      end
      StExec: begin
        alu_enable = 1'b1;
        alu_funct3 = funct3_q;
        alu_data_1 = op_a_q;
        alu_data_2 = op_b_q;
        state_d    = StLatch;
      end
      StLatch: begin
        // ALU output registered at the end of EXEC is valid now.
        alu_funct3 = funct3_q;
        alu_data_1 = op_a_q;
        alu_data_2 = op_b_q;
        result_d   = alu_data_out;
        state_d    = StResp;
      end
      StResp: begin
        resp_data   = result_q;
        resp0_valid = !owner_q;
        resp1_valid = owner_q;
        if (resp_hs) begin
          if (FIXED_PRIORITY == 0) ptr_d = !owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and holding registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      funct3_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      funct3_q <= funct3_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one registered base ALU (one-cycle posedge-registered result, funct3-selected op) between two requesters, e.g. the execute stage and a debug/test port.
- Arbitrates with valid/ready request and response handshakes.
- Sequences the ALU through capture, execute and latch phases.
- Returns each result to the requester that issued it.
- Sits between the requesters and the ALU instance; the ALU itself is external to this block.

Parameters:
- XLEN, 32, operand/result width.
- FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_funct3  input  3  ALU op code for requester 0.
- req0_op_a  input  XLEN  operand 1 for requester 0.
- req0_op_b  input  XLEN  operand 2 for requester 0.
- req1_valid, req1_ready, req1_funct3, req1_op_a, req1_op_b: same as requester 0, for requester 1.
- resp0_valid  output  1  result available for requester 0.
- resp0_ready  input  1  requester 0 takes result.
- resp1_valid  output  1  result available for requester 1.
- resp1_ready  input  1  requester 1 takes result.
- resp_data  output  XLEN  result, shared by both responders.
- busy  output  1  high in any state other than IDLE.
- alu_enable  output  1  high in EXEC.
- alu_funct3  output  3  op to ALU.
- alu_data_1  output  XLEN  operand 1 to ALU.
- alu_data_2  output  XLEN  operand 2 to ALU.
- alu_data_out  input  XLEN  registered ALU result.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE; priority pointer = 0; owner = 0.
  - Holding and result registers = 0.
  - All outputs 0.
  - Asserting reset mid-operation aborts the operation silently; no response is issued.
- States: IDLE -> EXEC -> LATCH -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational, high only in IDLE and only for the granted requester.
  - Grant when one requester is valid: that requester.
  - Grant when both are valid: FIXED_PRIORITY=1 gives requester 0. Otherwise the requester named by the priority pointer wins.
  - On grant: capture funct3, op_a, op_b and owner into holding registers; go to EXEC.
  - Never assert both ready signals in the same cycle.
- EXEC:
  - alu_enable = 1.
  - alu_funct3 / alu_data_1 / alu_data_2 are driven from the holding registers. They are held stable through EXEC and LATCH, and are 0 in IDLE.
  - The ALU registers the result at the end of this cycle.
  - Next state: LATCH.
- LATCH:
  - result register <= alu_data_out at the end of the cycle.
  - Next state: RESP.
- RESP:
  - resp_data = result register, held stable.
  - resp<owner>_valid = 1; the other resp valid stays 0.
  - Stay in RESP until resp<owner>_ready.
  - On handshake: go to IDLE. In round-robin mode, the pointer <= the requester that was not the owner.
  - resp_data returns to 0 in IDLE.
- Latency:
  - Request accepted at cycle T -> resp_valid first high at T+3.
  - Minimum 4 cycles per operation; no overlap of operations.
- Widths: XLEN-wide data paths pass through unchanged; the block performs no arithmetic itself.
- Requests not granted keep their valid high; the block never drops them.
- A request arriving during EXEC/LATCH/RESP is not granted until the next IDLE cycle.
- resp_ready on the non-owner side is ignored.

Test Plan:
- Requester 0 ADD (funct3=0), a=5, b=7, resp0_ready=1 -> req0_ready at T; resp0_valid and resp_data=12 at T+3; busy high for T+1..T+3.
- Both requesters valid at the same cycle, round-robin: requester 0 XOR 0xF0^0x0F, requester 1 OR 0x1|0x2 -> requester 0 served first with 0xFF. Requester 1 is then granted in the next IDLE cycle with 0x3. A following tie is won by requester 0 again, because the pointer returned to 0.
- FIXED_PRIORITY=1, both valid continuously -> requester 0 is granted every operation and requester 1 is starved. This is the required behaviour.
- Backpressure: requester 1 AND 0xFFFF0000&0x12345678 with resp1_ready low for 5 cycles -> resp1_valid and resp_data=0x12340000 held stable. There is no new grant until the handshake; then IDLE.
- SLL a=1, b=4 -> result 0x10; ALU inputs are stable across EXEC and LATCH, and alu_enable is high only in EXEC.
- reset_n pulsed low during LATCH -> all outputs 0 immediately; state IDLE; no resp_valid; a new request after release completes normally.
